// File: rtl/mem_byte_sequencer_pkg.sv
// Shared types for the byte-wide SRAM sequencer: FSM state encoding and beat counts.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} memState_t;

  localparam int BEATS_WORD = 4;
  localparam int BEATS_BYTE = 1;

  function automatic logic [1:0] lastBeat(input logic isWord);
    return isWord ? 2'(BEATS_WORD - 1) : 2'(BEATS_BYTE - 1);
  endfunction

endpackage

// File: rtl/mem_byte_sequencer_timer.sv
// Loadable down-counter that stretches each SRAM beat by the programmed wait states.
module mem_wait_timer
  import mem_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_load,
  input  logic [3:0] i_loadValue,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  // Load wins over decrement so a beat boundary can restart the count in one edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/mem_byte_sequencer.sv
// Runs one or four byte beats against a byte-wide SRAM for each captured load/store request.
// Define MEM_ALIGN_CHECK_EN to reject misaligned word requests with a MemErr pulse.
module mem_byte_sequencer
  import mem_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemEnable,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic              MemLength,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData,
  output logic              MemRdy,
  output logic              MemErr,
  output logic              Busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              sram_we,
  output logic              sram_oe
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  memState_t         r_state;
  memState_t         w_nextState;
  logic              r_reqPrev;
  logic              r_isRead;
  logic              r_isWord;
  logic [1:0]        r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wrData;
  logic [31:0]       r_rdData;
  logic              r_sramWe;
  logic              r_sramOe;
  logic [ADDR_W-1:0] r_sramAddr;
  logic [7:0]        r_sramWdata;
  logic [31:0]       w_unusedAddr;

  logic       w_capture;
  logic       w_misaligned;
  logic       w_timerZero;
  logic       w_beatDone;
  logic       w_lastBeat;
  logic [1:0] w_nextBeat;
  logic       w_strobeRead;
  logic       w_oeNext;
  logic       w_weNext;

  assign w_unusedAddr = Addr;

  // Only a fresh 0->1 edge on Rd|Wr starts an access; held or dual requests never retrigger
  assign w_capture  = (r_state == IDLE) && MemEnable && (MemRd ^ MemWr) && !r_reqPrev;
  assign w_beatDone = (r_state == ACCESS) && w_timerZero;
  assign w_lastBeat = (r_beat == lastBeat(r_isWord));
  assign w_nextBeat = r_beat + 2'd1;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_err;

  assign w_misaligned = MemLength && (Addr[1:0] != 2'b00);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_err <= 1'b0;
    end else if (w_capture) begin
      r_err <= w_misaligned;
    end
  end

  assign MemErr = (r_state == DONE) && r_err;
`else
  assign w_misaligned = 1'b0;
  assign MemErr       = 1'b0;
`endif

  mem_wait_timer u_waitTimer (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_load     (w_capture || (w_beatDone && !w_lastBeat)),
    .i_loadValue(WAIT_LOAD),
    .i_dec      (r_state == ACCESS),
    .o_zero     (w_timerZero)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_nextState = w_misaligned ? DONE : ACCESS;
      ACCESS:  if (w_timerZero) w_nextState = w_lastBeat ? DONE : GAP;
      GAP:     w_nextState = ACCESS;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Strobes are computed from the next state so the registered copies are high exactly in ACCESS
  always_comb begin
    MemRdy       = (r_state == DONE);
    Busy         = (r_state != IDLE);
    w_strobeRead = (r_state == IDLE) ? MemRd : r_isRead;
    w_oeNext     = (w_nextState == ACCESS) && w_strobeRead;
    w_weNext     = (w_nextState == ACCESS) && !w_strobeRead;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_reqPrev   <= 1'b0;
      r_isRead    <= 1'b0;
      r_isWord    <= 1'b0;
      r_beat      <= '0;
      r_addr      <= '0;
      r_wrData    <= '0;
      r_rdData    <= '0;
      r_sramWe    <= 1'b0;
      r_sramOe    <= 1'b0;
      r_sramAddr  <= '0;
      r_sramWdata <= '0;
    end else begin
      r_reqPrev <= MemRd | MemWr;
      r_sramWe  <= w_weNext;
      r_sramOe  <= w_oeNext;
      if (w_capture) begin
        r_isRead    <= MemRd;
        r_isWord    <= MemLength;
        r_addr      <= Addr[ADDR_W-1:0];
        r_wrData    <= WrData;
        r_beat      <= '0;
        r_sramAddr  <= Addr[ADDR_W-1:0];
        r_sramWdata <= WrData[7:0];
        if (MemRd && !MemLength) begin
          r_rdData[31:8] <= '0;
        end
      end else if (w_beatDone) begin
        if (r_isRead) begin
          r_rdData[{r_beat, 3'b000} +: 8] <= sram_rdata;
        end
        // Address and data for the next beat settle during GAP while both strobes are low
        if (!w_lastBeat) begin
          r_beat      <= w_nextBeat;
          r_sramAddr  <= r_addr + ADDR_W'(w_nextBeat);
          r_sramWdata <= r_wrData[{w_nextBeat, 3'b000} +: 8];
        end
      end
    end
  end

  assign RdData     = r_rdData;
  assign sram_we    = r_sramWe;
  assign sram_oe    = r_sramOe;
  assign sram_addr  = r_sramAddr;
  assign sram_wdata = r_sramWdata;

endmodule
